// File: rtl/vmon_wb_arb_pkg.sv
// Shared types and helpers for the vmon m2h Wishbone write arbiter.
package vmon_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit n set means a byte count of n is accepted (1, 2 and 4).
  localparam logic [7:0] LEGAL_SIZE_SET = 8'b0001_0110;

  function automatic logic size_is_legal(input logic [2:0] size);
    return LEGAL_SIZE_SET[size];
  endfunction

  function automatic logic [3:0] size_to_sel(input logic [2:0] size);
    logic [3:0] sel;
    case (size)
      3'd1:    sel = 4'b0001;
      3'd2:    sel = 4'b0011;
      3'd4:    sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/vmon_rr_arb.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module vmon_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  int cand;

  // Walk offsets from the far end so the nearest candidate to rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = (int'(rr_ptr) + off) % N_REQ;
      if (valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_vmon_m2h_arbiter.sv
// Round-robin arbiter serialising producer messages into Wishbone single writes
// to the vmon monitor address. Define VMON_ARB_TIMEOUT_EN to add an ACK watchdog.
//
// state | meaning
// IDLE  | waiting for any req_valid, picks the next requester round-robin
// BUS   | Wishbone write in flight, waiting for ACK/ERR (or watchdog)
// DONE  | completion pulse visible to the requester, round-robin pointer advances
module wb_vmon_m2h_arbiter
  import vmon_wb_arb_pkg::*;
#(
  parameter int                       N_REQ          = 4,
  parameter int                       WB_ADDR_WIDTH  = 32,
  parameter int                       WB_DATA_WIDTH  = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] MON_ADDR       = '0,
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*32-1:0]      req_data,
  input  logic [N_REQ*3-1:0]       req_size,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         req_err,
  output logic [WB_ADDR_WIDTH-1:0] ADR,
  output logic [WB_DATA_WIDTH-1:0] DAT_W,
  output logic [3:0]               SEL,
  output logic                     CYC,
  output logic                     STB,
  output logic                     WE,
  input  logic                     ACK,
  input  logic                     ERR
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [3:0]               sel_q, sel_d;
  logic                     cyc_q, cyc_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [N_REQ-1:0]         rdy_q, rdy_d;
  logic [N_REQ-1:0]         rerr_q, rerr_d;

  logic                     arb_valid;
  logic [IDX_W-1:0]         arb_idx;
  logic [WB_DATA_WIDTH-1:0] arb_data;
  logic [2:0]               arb_size;

`ifdef VMON_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  vmon_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .valid       (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  always_comb begin
    arb_data = '0;
    arb_size = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        arb_data = req_data[32*i +: 32];
        arb_size = req_size[3*i +: 3];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    cyc_d    = cyc_q;
    rdy_d    = '0;
    rerr_d   = '0;
`ifdef VMON_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          dat_d   = arb_data;
          sel_d   = size_to_sel(arb_size);
          if (size_is_legal(arb_size)) begin
            state_d = BUS;
            cyc_d   = 1'b1;
`ifdef VMON_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Illegal size completes with an error and never touches the bus.
            state_d         = DONE;
            rdy_d[arb_idx]  = 1'b1;
            rerr_d[arb_idx] = 1'b1;
          end
        end
      end
      BUS: begin
        if (ACK || ERR) begin
          state_d         = DONE;
          cyc_d           = 1'b0;
          rdy_d[grant_q]  = 1'b1;
          rerr_d[grant_q] = ERR;
        end
`ifdef VMON_ARB_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          state_d         = DONE;
          cyc_d           = 1'b0;
          rdy_d[grant_q]  = 1'b1;
          rerr_d[grant_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE: begin
        rr_ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    adr_d = cyc_d ? MON_ADDR : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      cyc_q    <= 1'b0;
      adr_q    <= '0;
      rdy_q    <= '0;
      rerr_q   <= '0;
`ifdef VMON_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      rdy_q    <= rdy_d;
      rerr_q   <= rerr_d;
`ifdef VMON_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign ADR       = adr_q;
  assign DAT_W     = dat_q;
  assign SEL       = sel_q;
  assign CYC       = cyc_q;
  assign STB       = cyc_q;
  assign WE        = cyc_q;
  assign req_ready = rdy_q;
  assign req_err   = rerr_q;

endmodule

// File: tb/tb_wb_vmon_m2h_arbiter.sv
// Scoreboard bench for wb_vmon_m2h_arbiter; VMON_ARB_TIMEOUT_EN selects the watchdog scenario.
module tb_wb_vmon_m2h_arbiter;

  localparam int          N   = 4;
  localparam logic [31:0] MON = 32'hA000_0010;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*32-1:0]   req_data = '0;
  logic [N*3-1:0]    req_size = '0;
  logic [N-1:0]      req_ready, req_err;
  logic [31:0]       ADR, DAT_W;
  logic [3:0]        SEL;
  logic              CYC, STB, WE;
  logic              ACK = 1'b0, ERR = 1'b0;

  always #5 clk_i = ~clk_i;

  wb_vmon_m2h_arbiter #(
    .N_REQ(N), .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32),
    .MON_ADDR(MON), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_data(req_data), .req_size(req_size),
    .req_ready(req_ready), .req_err(req_err),
    .ADR(ADR), .DAT_W(DAT_W), .SEL(SEL), .CYC(CYC), .STB(STB), .WE(WE),
    .ACK(ACK), .ERR(ERR)
  );

  typedef struct {
    bit          is_wr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          idx;
    bit          err;
    bit          from_bus;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0, errors = 0;
  int   rem[N];
  int   ack_delay = 0;
  bit   no_ack = 0, err_once = 0;
  int   last_len = 0, cur_len = 0, gap = 100;
  bit   rdy_seen = 0;
  logic prev_cyc = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [3:0] sel, input logic [31:0] dat);
    exp_t x;
    x.is_wr = 1; x.sel = sel; x.dat = dat; x.idx = 0; x.err = 0; x.from_bus = 0;
    sbq.push_back(x);
  endtask

  task automatic push_done(input int idx, input bit err, input bit from_bus);
    exp_t x;
    x.is_wr = 0; x.sel = '0; x.dat = '0; x.idx = idx; x.err = err; x.from_bus = from_bus;
    sbq.push_back(x);
  endtask

  task automatic set_req(input int i, input logic [2:0] size, input logic [31:0] data, input int n);
    req_data[i*32 +: 32] = data;
    req_size[i*3 +: 3]   = size;
    rem[i]               = n;
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending events, required 0", sbq.size());
      sbq.delete();
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  // Monitor: pops the scoreboard on each new bus cycle and each completion pulse.
  initial forever begin
    @(negedge clk_i);
    if (CYC && !prev_cyc) begin
      chk("idle_gap", 32'(gap >= (rdy_seen ? 2 : 1)), 32'd1);
      chk("stb_we", {30'd0, STB, WE}, 32'd3);
      rdy_seen = 0;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got SEL %h DAT_W %h, required no write", SEL, DAT_W);
      end else begin
        e = sbq.pop_front();
        chk("event_is_write", 32'(CYC), 32'(e.is_wr));
        if (e.is_wr) begin
          chk("wr_sel", SEL, e.sel);
          chk("wr_dat", DAT_W, e.dat);
          chk("wr_adr", ADR, MON);
        end
      end
    end
    if (CYC) begin
      cur_len = prev_cyc ? cur_len + 1 : 1;
      gap = 0;
    end else begin
      if (prev_cyc) last_len = cur_len;
      gap++;
    end
    if (req_ready != '0) begin
      rdy_seen = 1;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: got req_ready %b req_err %b, required none", req_ready, req_err);
      end else begin
        e = sbq.pop_front();
        chk("event_is_done", 32'(e.is_wr), 32'd0);
        chk("ready_vec", 32'(req_ready), 32'd1 << e.idx);
        chk("err_vec", 32'(req_err), e.err ? (32'd1 << e.idx) : 32'd0);
        chk("ready_cyc_low", 32'(CYC), 32'd0);
        chk("ready_after_bus", 32'(prev_cyc), 32'(e.from_bus));
      end
    end
    prev_cyc = CYC;
  end

  // Wishbone slave model.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk_i);
      #2;
      ACK = 1'b0;
      ERR = 1'b0;
      if (CYC) begin
        if (!no_ack && cnt >= ack_delay) begin
          if (err_once) begin
            ERR = 1'b1;
            err_once = 0;
          end else begin
            ACK = 1'b1;
          end
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Requesters drop valid after their programmed number of completions.
  initial forever begin
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && rem[i] > 0) begin
        rem[i]--;
        if (rem[i] == 0) req_valid[i] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got time limit reached, required $finish earlier");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < N; i++) rem[i] = 0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cyc", {29'd0, CYC, STB, WE}, 32'd0);
    chk("rst_sel", SEL, 32'd0);
    chk("rst_dat", DAT_W, 32'd0);
    chk("rst_adr", ADR, 32'd0);
    chk("rst_ready", {req_ready, req_err}, 32'd0);
    rst_i = 1'b0;

    // Single request, ACK two cycles after CYC.
    ack_delay = 2;
    push_wr(4'b1111, 32'hDDCCBBAA);
    push_done(0, 0, 1);
    set_req(0, 3'd4, 32'hDDCCBBAA, 1);
    wait_drain(50);
    chk("t1_cyc_len", last_len, 32'd3);

    // All four valid out of reset, immediate ACK: order 0,1,2,3,0.
    rst_i = 1'b1;
    ack_delay = 0;
    push_wr(4'b1111, 32'hA0A0A0A0); push_done(0, 0, 1);
    push_wr(4'b0001, 32'hB1B1B1B1); push_done(1, 0, 1);
    push_wr(4'b0011, 32'hC2C2C2C2); push_done(2, 0, 1);
    push_wr(4'b1111, 32'hD3D3D3D3); push_done(3, 0, 1);
    push_wr(4'b1111, 32'hA0A0A0A0); push_done(0, 0, 1);
    set_req(0, 3'd4, 32'hA0A0A0A0, 2);
    set_req(1, 3'd1, 32'hB1B1B1B1, 1);
    set_req(2, 3'd2, 32'hC2C2C2C2, 1);
    set_req(3, 3'd4, 32'hD3D3D3D3, 1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    wait_drain(200);

    // ERR on requester 1 (rr_ptr is 1), then grants continue at 3 and wrap to 0.
    err_once = 1;
    push_wr(4'b0011, 32'h00002222); push_done(1, 1, 1);
    push_wr(4'b1111, 32'h33333333); push_done(3, 0, 1);
    push_wr(4'b0001, 32'h00000011); push_done(0, 0, 1);
    set_req(0, 3'd1, 32'h00000011, 1);
    set_req(1, 3'd2, 32'h00002222, 1);
    set_req(3, 3'd4, 32'h33333333, 1);
    wait_drain(100);

    // Illegal size 3 on requester 2: error completion one cycle after grant, no bus cycle.
    push_done(2, 1, 0);
    set_req(2, 3'd3, 32'hBAD00003, 1);
    @(posedge clk_i);
    #1;
    chk("t4_ready", 32'(req_ready), 32'h4);
    chk("t4_err", 32'(req_err), 32'h4);
    chk("t4_no_cyc", 32'(CYC), 32'd0);
    wait_drain(20);

    // Reset mid-BUS: aborted request gets no pulse, arbitration restarts at 0.
    no_ack = 1;
    push_wr(4'b1111, 32'h44444444);
    set_req(3, 3'd4, 32'h44444444, 1);
    repeat (5) @(posedge clk_i);
    #1;
    chk("t5_cyc_before_rst", 32'(CYC), 32'd1);
    push_wr(4'b0001, 32'h00000055); push_done(1, 0, 1);
    push_wr(4'b1111, 32'h44444444); push_done(3, 0, 1);
    rst_i = 1'b1;
    set_req(1, 3'd1, 32'h00000055, 1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    no_ack = 0;
    chk("t5_rst_cyc", {29'd0, CYC, STB, WE}, 32'd0);
    chk("t5_rst_sel", SEL, 32'd0);
    chk("t5_rst_dat", DAT_W, 32'd0);
    chk("t5_rst_adr", ADR, 32'd0);
    chk("t5_rst_ready", {req_ready, req_err}, 32'd0);
    wait_drain(100);

    // No ACK at all: watchdog (when built in) or indefinite wait.
    no_ack = 1;
    push_wr(4'b0011, 32'h12345678);
`ifdef VMON_ARB_TIMEOUT_EN
    push_done(0, 1, 1);
    set_req(0, 3'd2, 32'h12345678, 1);
    wait_drain(100);
    chk("t6_timeout_len", last_len, 32'd8);
    no_ack = 0;
`else
    set_req(0, 3'd2, 32'h12345678, 1);
    repeat (120) @(posedge clk_i);
    #1;
    chk("t6_cyc_held", 32'(CYC), 32'd1);
    chk("t6_cyc_len_100", 32'(cur_len >= 100), 32'd1);
    push_done(0, 0, 1);
    no_ack = 0;
    wait_drain(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_vmon_m2h_arbiter.md
# wb_vmon_m2h_arbiter

Round-robin arbiter and Wishbone write sequencer that lets up to N_REQ independent message producers share the single monitored Wishbone window feeding the vmon m2h channel. Each requester hands over 1, 2 or 4 bytes. The block serialises the requests into Wishbone single writes (CYC/STB/WE/SEL/DAT_W) to a fixed monitor address. It completes each request on ACK or ERR, and sits between the producers and the Wishbone slave port observed by wb_vmon_monitor.

## Interface
Parameters:
- N_REQ, default 4: number of requesters, 2..8.
- WB_ADDR_WIDTH, default 32: Wishbone address width.
- WB_DATA_WIDTH, default 32: Wishbone data width; only 32 is supported.
- MON_ADDR, default 32'h0: address driven on ADR for every cycle.
- TIMEOUT_CYCLES, default 255: ACK watchdog limit; used only when VMON_ARB_TIMEOUT_EN is defined.

Ports:
- clk_i, in, 1: the single clock; all logic samples on its rising edge.
- rst_i, in, 1: synchronous reset, active-high.
- req_valid, in, N_REQ: request pending per requester.
- req_data, in, N_REQ*32: requester i occupies bits [32i+31:32i]; bytes are packed from bit 0.
- req_size, in, N_REQ*3: byte count per requester; 1, 2 and 4 are legal.
- req_ready, out, N_REQ: one-cycle completion pulse to the granted requester.
- req_err, out, N_REQ: qualified by req_ready; 1 means bus ERR, timeout or illegal size.
- ADR, out, WB_ADDR_WIDTH: always MON_ADDR while CYC is high.
- DAT_W, out, 32: latched request data.
- SEL, out, 4: byte enables.
- CYC, out, 1: Wishbone cycle.
- STB, out, 1: Wishbone strobe.
- WE, out, 1: write enable; always 1 while CYC is high.
- ACK, in, 1: slave acknowledge.
- ERR, in, 1: slave error.

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - With any req_valid set, grant the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - Latch the grant index, data and size.
  - Legal size: go to BUS.
  - Illegal size: go to DONE with err=1; no bus cycle is issued.
- Size-to-SEL mapping: 1 → 4'b0001, 2 → 4'b0011, 4 → 4'b1111. DAT_W is the full latched word.
- BUS:
  - CYC, STB and WE are held at 1, with ADR, DAT_W and SEL stable.
  - ACK → DONE with err=0.
  - ERR, or ACK and ERR together → DONE with err=1.
- DONE:
  - Pulse req_ready[grant] and drive req_err[grant] = err.
  - Set rr_ptr = (grant+1) mod N_REQ.
  - Go to IDLE.
- Requester rules:
  - A requester must hold valid, data and size stable until its req_ready pulse.
  - Deasserting valid early is a protocol violation; the started cycle still completes.
- rr_ptr advances only in DONE. A requester with valid held never waits more than N_REQ−1 other grants.
- Reset values:
  - State: IDLE. rr_ptr: 0.
  - CYC, STB, WE: 0. SEL: 0. DAT_W: 0. ADR: 0.
  - req_ready, req_err: 0.
- Reset mid-cycle: CYC drops on the next edge and no req_ready pulse is issued for the aborted request.

## Timing
- All outputs are registered.
- req_valid sampled high in IDLE at edge t → CYC/STB high from t+1.
- ACK sampled at edge k → CYC low and req_ready pulse during cycle k+1. The next CYC rises no earlier than k+3.
- Illegal size: req_ready/req_err pulse one cycle after the grant edge.
- CYC and STB are high together for at least one cycle. No back-to-back cycles without an idle cycle between them.

## Configuration
- VMON_ARB_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entry to BUS and increments every BUS cycle.
  - When the count reaches TIMEOUT_CYCLES without ACK or ERR, drop CYC and go to DONE with err=1.
- VMON_ARB_TIMEOUT_EN undefined: no counter logic. BUS waits indefinitely for ACK or ERR.

## Structure
- Package vmon_wb_arb_pkg holds:
  - the state enum (IDLE, BUS, DONE);
  - the size-to-SEL function;
  - the legal-size check constant set.
- Sub-module vmon_rr_arb: combinational N_REQ-wide round-robin priority picker. Inputs are valid and rr_ptr; outputs are grant_valid and grant_idx.

## Test plan
- Single request: requester 0, size 4, data 32'hDDCCBBAA; ACK 2 cycles after CYC → one write with SEL 4'b1111 and DAT_W 32'hDDCCBBAA, then req_ready[0]=1 with req_err[0]=0.
- All 4 requesters valid from reset, ACK immediate → grant order 0,1,2,3,0; SEL follows each requester's size (1 → 4'b0001, 2 → 4'b0011).
- Size 3 on requester 2 → no CYC; req_ready[2]=1 with req_err[2]=1 one cycle after the grant.
- ERR instead of ACK for requester 1 → req_err[1]=1, rr_ptr=2, and the next grant goes to the next valid requester at or after index 2.
- VMON_ARB_TIMEOUT_EN defined with TIMEOUT_CYCLES=8 and no ACK → CYC drops after 8 BUS cycles and req_err=1; without the macro, CYC stays high for 100+ cycles.
- rst_i asserted for one cycle mid-BUS → CYC=0 and all outputs at reset values next cycle, no req_ready pulse, rr_ptr=0; arbitration then restarts from requester 0.
